// File: rtl/pic_pkg.sv
// pic_pkg: shared types and encodings for the 8259-style interrupt sequencer.
//   pic_state_e : INTA sequencing states (IDLE, REQ, ACK1, ACK2)
//   NS_EOI/S_EOI: OCW2 command codes carried in d[7:5]
//   ICWn/OCWn   : wr_nr encodings of the decoded control-word strobes
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK1 = 2'd2,
    ACK2 = 2'd3
  } pic_state_e;

  localparam logic [2:0] NS_EOI = 3'b001;
  localparam logic [2:0] S_EOI  = 3'b011;

  localparam logic [1:0] ICW1 = 2'd0;
  localparam logic [1:0] ICW2 = 2'd1;
  localparam logic [1:0] ICW3 = 2'd2;
  localparam logic [1:0] ICW4 = 2'd3;
  localparam logic [1:0] OCW1 = 2'd0;
  localparam logic [1:0] OCW2 = 2'd1;
  localparam logic [1:0] OCW3 = 2'd2;

endpackage

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: 8-bit masked find-first-set. Index 0 is the
// highest priority.
//   req   : request vector
//   mask  : 1 = bit ignored
//   idx   : lowest set index of req & ~mask (0 when none)
//   valid : at least one unmasked request
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] req,
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic       valid
);

  logic [7:0] eff;
  assign eff = req & ~mask;

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx   = 3'd0;
    valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (eff[i]) begin
        idx   = i[2:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pic_int_sequencer.sv
// pic_int_sequencer: single-PIC interrupt sequencing core. Owns IRR, ISR and
// IMR, runs fully-nested priority, drives int_out and sequences the two-pulse
// INTA handshake that presents the vector.
//   clk, rst_n               : clock, asynchronous active-low reset
//   wr_stb/wr_type/wr_nr/wr_data : decoded ICW/OCW write strobe and byte
//   rd_a0, rd_data           : status readback (IMR, or IRR/ISR per OCW3)
//   ir                       : asynchronous request lines
//   inta_n                   : asynchronous acknowledge, active low
//   int_out                  : interrupt request to the CPU
//   vec_data, vec_oe         : vector byte and its bus enable
//
// Handshake: int_out is the request; the CPU's first inta falling edge is the
// acknowledge that commits the level (int_out drops). The second falling edge
// loads vec_data and raises vec_oe, which stays high until inta rises again.
// inta edges outside that sequence are ignored.
module pic_int_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_stb,
  input  logic       wr_type,
  input  logic [1:0] wr_nr,
  input  logic [7:0] wr_data,
  input  logic       rd_a0,
  output logic [7:0] rd_data,
  input  logic [7:0] ir,
  input  logic       inta_n,
  output logic       int_out,
  output logic [7:0] vec_data,
  output logic       vec_oe
);

  // Synchronizers and edge detection.
  logic [SYNC_STAGES-1:0][7:0] ir_sync;
  logic [SYNC_STAGES-1:0]      inta_sync;
  logic [7:0] ir_s, ir_prev, ir_rise;
  logic       inta_s, inta_d, inta_fall, inta_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_sync   <= '0;
      inta_sync <= '1;
      inta_d    <= 1'b1;
    end else begin
      ir_sync   <= {ir_sync[SYNC_STAGES-2:0], ir};
      inta_sync <= {inta_sync[SYNC_STAGES-2:0], inta_n};
      inta_d    <= inta_s;
    end
  end

  assign ir_s      = ir_sync[SYNC_STAGES-1];
  assign inta_s    = inta_sync[SYNC_STAGES-1];
  assign inta_fall = inta_d & ~inta_s;
  assign inta_rise = ~inta_d & inta_s;
  assign ir_rise   = ir_s & ~ir_prev;

  // Control-word decode.
  logic icw1_wr, icw2_wr, icw3_wr, icw4_wr, ocw1_wr, ocw2_wr, ocw3_wr;
  assign icw1_wr = wr_stb &  wr_type & (wr_nr == ICW1);
  assign icw2_wr = wr_stb &  wr_type & (wr_nr == ICW2);
  assign icw3_wr = wr_stb &  wr_type & (wr_nr == ICW3);
  assign icw4_wr = wr_stb &  wr_type & (wr_nr == ICW4);
  assign ocw1_wr = wr_stb & ~wr_type & (wr_nr == OCW1);
  assign ocw2_wr = wr_stb & ~wr_type & (wr_nr == OCW2);
  assign ocw3_wr = wr_stb & ~wr_type & (wr_nr == OCW3);

  // Registers.
  pic_state_e state, state_next;
  logic [7:0] irr, isr, imr;
  logic [4:0] base;
  logic       ltim, ic4, sngl, aeoi, rr_sel, init_done;
  logic [2:0] lvl;
  logic       spur;

  // Priority.
  logic [2:0] cand_idx, isr_idx;
  logic       cand_v, isr_v, pending;

  pic_priority_resolver u_cand_res (
    .req   (irr),
    .mask  (imr),
    .idx   (cand_idx),
    .valid (cand_v)
  );

  pic_priority_resolver u_isr_res (
    .req   (isr),
    .mask  (8'h00),
    .idx   (isr_idx),
    .valid (isr_v)
  );

  assign pending = cand_v & (~isr_v | (cand_idx < isr_idx));

  // Next-state and handshake events.
  logic ack_take, vec_load, vec_rel;

  always_comb begin
    state_next = state;
    ack_take   = 1'b0;
    vec_load   = 1'b0;
    vec_rel    = 1'b0;
    case (state)
      IDLE: if (pending && init_done) state_next = REQ;
      REQ:  if (inta_fall) begin ack_take = 1'b1; state_next = ACK1; end
      ACK1: if (inta_fall) begin vec_load = 1'b1; state_next = ACK2; end
      ACK2: if (inta_rise) begin vec_rel  = 1'b1; state_next = IDLE; end
      default: state_next = IDLE;
    endcase
  end

  // ISR/IRR update. EOI targets come from the pre-cycle ISR; a set applied
  // after the clears wins on a collision.
  logic [7:0] ack_set, eoi_clr, aeoi_clr, isr_next, irr_next;

  always_comb begin
    ack_set  = (ack_take && cand_v) ? (8'd1 << cand_idx) : 8'd0;
    eoi_clr  = 8'd0;
    if (ocw2_wr) begin
      if (wr_data[7:5] == NS_EOI && isr_v) eoi_clr = 8'd1 << isr_idx;
      else if (wr_data[7:5] == S_EOI)      eoi_clr = 8'd1 << wr_data[2:0];
    end
    aeoi_clr = (vec_rel && aeoi && !spur) ? (8'd1 << lvl) : 8'd0;
    isr_next = (isr & ~(eoi_clr | aeoi_clr)) | ack_set;
    if (ltim) irr_next = ir_s & ~(isr | ack_set);
    else      irr_next = (irr & ~ack_set) | ir_rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      irr       <= '0;
      isr       <= '0;
      imr       <= '0;
      ir_prev   <= '0;
      base      <= '0;
      ltim      <= 1'b0;
      ic4       <= 1'b0;
      sngl      <= 1'b0;
      aeoi      <= 1'b0;
      rr_sel    <= 1'b0;
      init_done <= 1'b0;
      lvl       <= '0;
      spur      <= 1'b0;
      int_out   <= 1'b0;
      vec_oe    <= 1'b0;
      vec_data  <= '0;
    end else if (icw1_wr) begin
      // Edge history set to all-ones so only a fresh low-to-high counts.
      irr       <= '0;
      isr       <= '0;
      imr       <= '0;
      ir_prev   <= 8'hFF;
      ltim      <= wr_data[3];
      sngl      <= wr_data[1];
      ic4       <= wr_data[0];
      init_done <= 1'b0;
      state     <= IDLE;
      int_out   <= 1'b0;
      vec_oe    <= 1'b0;
    end else begin
      ir_prev <= ir_s;
      irr     <= irr_next;
      isr     <= isr_next;
      state   <= state_next;
      int_out <= (state_next == REQ);
      if (ocw1_wr) imr <= wr_data;
      if (ocw3_wr && wr_data[1]) rr_sel <= wr_data[0];
      if (icw2_wr) begin
        base <= wr_data[7:3];
        if (!ic4 && sngl) init_done <= 1'b1;
      end
      if (icw3_wr && !ic4) init_done <= 1'b1;
      if (icw4_wr) begin
        aeoi      <= wr_data[1];
        init_done <= 1'b1;
      end
      if (ack_take) begin
        lvl  <= cand_v ? cand_idx : 3'd7;
        spur <= ~cand_v;
      end
      if (vec_load) begin
        vec_data <= {base, lvl};
        vec_oe   <= 1'b1;
      end
      if (vec_rel) vec_oe <= 1'b0;
    end
  end

  assign rd_data = rd_a0 ? imr : (rr_sel ? isr : irr);

endmodule

// File: tb/tb_pic_int_sequencer.sv
// tb_pic_int_sequencer: directed bench for pic_int_sequencer. Expected vectors
// are queued when the request is driven and checked when vec_oe rises.
module tb_pic_int_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_stb;
  logic       wr_type;
  logic [1:0] wr_nr;
  logic [7:0] wr_data;
  logic       rd_a0;
  logic [7:0] rd_data;
  logic [7:0] ir;
  logic       inta_n;
  logic       int_out;
  logic [7:0] vec_data;
  logic       vec_oe;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [7:0] exp_q[$];

  pic_int_sequencer #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_stb   (wr_stb),
    .wr_type  (wr_type),
    .wr_nr    (wr_nr),
    .wr_data  (wr_data),
    .rd_a0    (rd_a0),
    .rd_data  (rd_data),
    .ir       (ir),
    .inta_n   (inta_n),
    .int_out  (int_out),
    .vec_data (vec_data),
    .vec_oe   (vec_oe)
  );

  // Clock.
  always #5 clk = ~clk;

  // Driver and checker tasks. Inputs change and outputs are sampled on the
  // falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic typ, input logic [1:0] nr, input logic [7:0] d);
    wr_type = typ;
    wr_nr   = nr;
    wr_data = d;
    wr_stb  = 1'b1;
    step(1);
    wr_stb  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic a0, input logic [7:0] exp);
    rd_a0 = a0;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic read_isr(input string tag, input logic [7:0] exp);
    wr(1'b0, 2'd2, 8'h0B);
    rd_chk(tag, 1'b0, exp);
  endtask

  task automatic read_irr(input string tag, input logic [7:0] exp);
    wr(1'b0, 2'd2, 8'h0A);
    rd_chk(tag, 1'b0, exp);
  endtask

  task automatic init_pic(input logic [7:0] icw4);
    wr(1'b1, 2'd0, 8'h13);
    wr(1'b1, 2'd1, 8'h40);
    wr(1'b1, 2'd3, icw4);
  endtask

  task automatic wait_int(input string tag);
    int k = 0;
    while (!int_out && k < 12) begin
      step(1);
      k++;
    end
    chk(tag, {7'd0, int_out}, 8'h01);
  endtask

  task automatic inta_low();
    inta_n = 1'b0;
    step(4);
  endtask

  task automatic inta_high();
    inta_n = 1'b1;
    step(4);
  endtask

  // Second INTA fall: wait (bounded) for vec_oe, then pop the scoreboard.
  task automatic inta_vec(input string tag);
    int k = 0;
    inta_n = 1'b0;
    while (!vec_oe && k < 10) begin
      step(1);
      k++;
    end
    chk({tag, "_oe"}, {7'd0, vec_oe}, 8'h01);
    if (exp_q.size() == 0) chk({tag, "_unexpected"}, vec_data, 8'hxx);
    else chk(tag, vec_data, exp_q.pop_front());
  endtask

  initial begin
    rst_n = 1'b0; wr_stb = 1'b0; wr_type = 1'b0; wr_nr = 2'd0; wr_data = 8'h00;
    rd_a0 = 1'b0; ir = 8'h00; inta_n = 1'b1;
    step(3);
    chk("rst_int_out", {7'd0, int_out}, 8'h00);
    chk("rst_vec_oe", {7'd0, vec_oe}, 8'h00);
    chk("rst_vec_data", vec_data, 8'h00);
    rd_chk("rst_irr", 1'b0, 8'h00);
    rd_chk("rst_imr", 1'b1, 8'h00);
    rst_n = 1'b1;
    step(2);

    // 1: init, ir[3] latency, full INTA sequence.
    init_pic(8'h01);
    ir = 8'h08;
    exp_q.push_back(8'h43);
    step(3);
    chk("t1_int_edge3", {7'd0, int_out}, 8'h00);
    rd_chk("t1_irr_set", 1'b0, 8'h08);
    step(1);
    chk("t1_int_edge4", {7'd0, int_out}, 8'h01);
    ir = 8'h00;
    inta_low();
    chk("t1_int_drop", {7'd0, int_out}, 8'h00);
    inta_high();
    inta_vec("t1_vec");
    step(3);
    inta_high();
    chk("t1_oe_release", {7'd0, vec_oe}, 8'h00);
    read_isr("t1_isr", 8'h08);
    read_irr("t1_irr", 8'h00);

    // 2: nesting blocks lower priority, higher priority preempts, NS EOI.
    ir = 8'h20;
    step(6);
    chk("t2_no_int_ir5", {7'd0, int_out}, 8'h00);
    ir = 8'h22;
    exp_q.push_back(8'h41);
    step(4);
    chk("t2_int_ir1", {7'd0, int_out}, 8'h01);
    inta_low();
    inta_high();
    inta_vec("t2_vec");
    inta_high();
    read_isr("t2_isr_nested", 8'h0A);
    wr(1'b0, 2'd1, 8'h20);
    read_isr("t2_isr_ns_eoi", 8'h08);
    read_irr("t2_irr", 8'h20);
    ir = 8'h00;

    // 3: masking, unmasking, and a spurious acknowledge.
    wr(1'b0, 2'd0, 8'h02);
    ir = 8'h02;
    step(6);
    chk("t3_masked", {7'd0, int_out}, 8'h00);
    read_irr("t3_irr", 8'h22);
    wr(1'b0, 2'd0, 8'h00);
    wait_int("t3_unmask_int");
    wr(1'b0, 2'd0, 8'hFF);
    chk("t3_int_held", {7'd0, int_out}, 8'h01);
    exp_q.push_back(8'h47);
    inta_low();
    inta_high();
    inta_vec("t3_spur_vec");
    inta_high();
    read_isr("t3_isr_unchanged", 8'h08);
    read_irr("t3_irr_kept", 8'h22);
    wr(1'b0, 2'd1, 8'h63);
    read_isr("t3_s_eoi", 8'h00);
    chk("t3_no_int_masked", {7'd0, int_out}, 8'h00);

    // 4: AEOI clears ISR on the inta rise after the vector.
    init_pic(8'h03);
    rd_chk("t4_imr_cleared", 1'b1, 8'h00);
    read_irr("t4_irr_cleared", 8'h00);
    ir = 8'h04;
    exp_q.push_back(8'h42);
    wait_int("t4_int");
    inta_low();
    inta_high();
    read_isr("t4_isr_in_service", 8'h04);
    inta_vec("t4_vec");
    read_isr("t4_isr_during_vec", 8'h04);
    inta_high();
    chk("t4_oe_release", {7'd0, vec_oe}, 8'h00);
    read_isr("t4_isr_aeoi", 8'h00);
    ir = 8'h00;

    // 5: readback selection.
    wr(1'b0, 2'd0, 8'h5A);
    rd_chk("t5_imr", 1'b1, 8'h5A);
    ir = 8'h40;
    step(6);
    chk("t5_no_int_masked", {7'd0, int_out}, 8'h00);
    read_irr("t5_irr", 8'h40);
    read_isr("t5_isr", 8'h00);
    wr(1'b0, 2'd2, 8'h09);
    rd_chk("t5_rr_sel_kept", 1'b0, 8'h00);
    wr(1'b0, 2'd2, 8'h08);
    wr(1'b0, 2'd2, 8'h0A);
    wr(1'b0, 2'd2, 8'h08);
    rd_chk("t5_rr_sel_irr_kept", 1'b0, 8'h40);

    // 6a: asynchronous reset while in ACK1.
    wr(1'b0, 2'd0, 8'h00);
    wait_int("t6_int");
    inta_low();
    chk("t6_vec_before", vec_data, 8'h42);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_int_out", {7'd0, int_out}, 8'h00);
    chk("t6_rst_vec_oe", {7'd0, vec_oe}, 8'h00);
    chk("t6_rst_vec_data", vec_data, 8'h00);
    rd_chk("t6_rst_imr", 1'b1, 8'h00);
    rd_chk("t6_rst_irr", 1'b0, 8'h00);
    inta_n = 1'b1;
    ir = 8'h00;
    step(2);
    rst_n = 1'b1;
    step(2);

    // 6b: ICW1 while the vector is on the bus.
    init_pic(8'h01);
    wr(1'b0, 2'd2, 8'h0B);
    ir = 8'h10;
    exp_q.push_back(8'h44);
    wait_int("t6_int2");
    inta_low();
    inta_high();
    inta_vec("t6_vec");
    rd_chk("t6_isr_before_icw1", 1'b0, 8'h10);
    wr(1'b1, 2'd0, 8'h13);
    chk("t6_icw1_vec_oe", {7'd0, vec_oe}, 8'h00);
    rd_chk("t6_icw1_isr", 1'b0, 8'h00);
    chk("t6_icw1_int_out", {7'd0, int_out}, 8'h00);
    inta_high();
    chk("t6_idle_rise_ignored", {7'd0, vec_oe}, 8'h00);

    chk("exp_q_empty", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_int_sequencer.md
Name: pic_int_sequencer

Overview:
Synchronous interrupt-sequencing controller for the 8259-style PIC. It consumes decoded ICW/OCW write strobes from the read/write logic and owns IRR, ISR and IMR. It runs the fully-nested priority decision, drives INT, and sequences the two-pulse INTA handshake that places the vector on the data bus. Single-PIC (non-cascade) configuration only.

Parameters:
SYNC_STAGES, 2, synchronizer depth for ir[7:0] and inta_n (min 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_stb  in  1  one-cycle pulse: a control word is valid
wr_type  in  1  1=ICW, 0=OCW
wr_nr  in  2  ICW1..4 = 0..3; OCW1/2/3 = 0/1/2
wr_data  in  8  control-word byte
rd_a0  in  1  read select: 0=IRR/ISR per OCW3, 1=IMR
rd_data  out  8  combinational status readback
ir  in  8  asynchronous interrupt request lines
inta_n  in  1  asynchronous CPU interrupt acknowledge, active low
int_out  out  1  interrupt request to CPU
vec_data  out  8  vector byte
vec_oe  out  1  vec_data valid; drives the data bus

Behaviour:
- Reset values: IRR=ISR=IMR=0; base=0; ltim=0; ic4=0; sngl=0; aeoi=0; rr_sel=0 (IRR); init_done=0; state IDLE; int_out=0; vec_oe=0; vec_data=0.
- ir and inta_n pass through SYNC_STAGES flops. inta edges are detected on the synchronized signal against its 1-cycle-delayed copy.
- ICW1 write:
  - Clears ISR, IMR, IRR and the edge history (a new low-to-high transition is required).
  - ltim=d[3], sngl=d[1], ic4=d[0], init_done=0.
  - Forces state IDLE, int_out=0, vec_oe=0.
  - Overrides every other same-cycle event.
- ICW2: base=d[7:3]. Sets init_done if ic4=0 and sngl=1.
- ICW3: no stored state. Sets init_done if ic4=0.
- ICW4: aeoi=d[1]. Sets init_done.
- OCW1: IMR=d.
- OCW2: d[7:5]=001 is non-specific EOI and clears the lowest-index set ISR bit. 011 is specific EOI and clears ISR[d[2:0]]. All other codes are ignored.
- OCW3: if d[1]=1 then rr_sel=d[0]; otherwise no change.
- IRR update:
  - Edge mode (ltim=0): the bit sets on a synchronized rising edge of ir and holds until serviced.
  - Level mode: the bit equals synchronized ir whenever it is not being serviced.
- Priority:
  - cand = IRR & ~IMR. L = lowest set index of cand. IR0 is highest.
  - pending = cand!=0 and (ISR==0 or L < lowest set ISR index).
- FSM:
  - IDLE: if pending and init_done, go to REQ. int_out=1 registered on that edge.
  - REQ: on the first inta falling edge, latch lvl = L and set ISR[lvl], clear IRR[lvl]. If cand=0 at that edge, latch lvl=7 with spur=1 and leave ISR untouched. Then go to ACK1 with int_out=0.
  - ACK1: on the second inta falling edge, vec_data={base,lvl} and vec_oe=1. Go to ACK2.
  - ACK2: hold vec_oe. On inta rising edge, vec_oe=0; if aeoi and !spur, clear ISR[lvl]. Go to IDLE.
  - inta edges in IDLE are ignored.
- Latency: from a synchronized ir rise (SYNC_STAGES=2), int_out is high on the 4th clk edge. vec_oe rises 1 cycle after the second synchronized inta fall.
- Simultaneous set and clear: EOI targets are computed from pre-cycle ISR. If an ISR set and an EOI clear hit the same bit, the set wins. An OCW1 mask change in REQ does not cancel INT; it is resolved as spurious at the first INTA.
- rd_data = rd_a0 ? IMR : (rr_sel ? ISR : IRR).

Decomposition:
- Package pic_pkg holds: state enum (IDLE, REQ, ACK1, ACK2); OCW2 command constants (NS_EOI=3'b001, S_EOI=3'b011); ICW/OCW nr encodings.
- Sub-module pic_priority_resolver: 8-bit masked find-first-set returning index and valid. It is instantiated twice, for cand and for ISR.

Test Plan:
1. Init sequence ICW1=0x13, ICW2=0x40, ICW4=0x01, pulse ir[3] -> int_out=1 on the 4th edge. After two INTA pulses, vec_data=0x43 with vec_oe=1; ISR=0x08, IRR=0.
2. ISR=0x08, raise ir[5] -> no int_out. Raise ir[1] -> int_out, vector 0x41. Non-specific EOI (OCW2=0x20) -> ISR=0x08.
3. OCW1=0x02, ir[1] rises -> no int_out. OCW1=0x00 -> int_out asserts. Set mask after int_out, then INTA ×2 -> vector 0x47, ISR unchanged.
4. ICW4=0x03 (AEOI), ir[2] serviced -> ISR[2] clears on the inta rising edge after vector; ISR=0.
5. OCW3=0x0B then rd_a0=0 -> rd_data=ISR. OCW3=0x0A -> IRR. rd_a0=1 -> IMR.
6. Assert rst_n=0 in ACK1 -> all outputs 0 immediately. ICW1 written in ACK2 -> IDLE, vec_oe=0, ISR=0 next cycle.
